// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-op code width and op-code constants.
// Used by logic_op_comb and logic_unit_pipe (and reusable by the main ALU).
package alu_pkg;

    localparam int unsigned LOGIC_OPW = 3;

    localparam logic [LOGIC_OPW-1:0] OP_AND  = 3'd0;
    localparam logic [LOGIC_OPW-1:0] OP_OR   = 3'd1;
    localparam logic [LOGIC_OPW-1:0] OP_XOR  = 3'd2;
    localparam logic [LOGIC_OPW-1:0] OP_NAND = 3'd3;
    localparam logic [LOGIC_OPW-1:0] OP_NOR  = 3'd4;
    localparam logic [LOGIC_OPW-1:0] OP_XNOR = 3'd5;
    localparam logic [LOGIC_OPW-1:0] OP_ANDN = 3'd6;
    localparam logic [LOGIC_OPW-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_op_comb.sv
// Purely combinational bitwise logic unit with result flags.
// Ports:
//   a_i, b_i   operands (WIDTH bits)
//   op_i       operation code (alu_pkg OP_*)
//   result_o   bitwise result
//   zero_o     result is all zeros
//   ones_o     result is all ones
//   parity_o   XOR-reduction of result
module logic_op_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [LOGIC_OPW-1:0] op_i,
    output logic [WIDTH-1:0]     result_o,
    output logic                 zero_o,
    output logic                 ones_o,
    output logic                 parity_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NAND: result_o = ~(a_i & b_i);
            OP_NOR:  result_o = ~(a_i | b_i);
            OP_XNOR: result_o = ~(a_i ^ b_i);
            OP_ANDN: result_o = a_i & ~b_i;
            OP_PASS: result_o = a_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o   = (result_o == '0);
    assign ones_o   = &result_o;
    assign parity_o = ^result_o;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with optional accumulate mode.
// S1 registers the operands; the logic op is evaluated between S1 and S2;
// S2 registers result and flags. Valid/ready on both sides, full throughput.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready               input handshake
//   in_a, in_b, in_op, in_acc       operands, op code, use-accumulator select
//   out_valid/out_ready             output handshake
//   out_data                        result
//   out_zero, out_ones, out_parity  flags of out_data
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  ACC_RESET = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [LOGIC_OPW-1:0] in_op,
    input  logic                 in_acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_zero,
    output logic                 out_ones,
    output logic                 out_parity
);

    // Stage 1
    logic                 s1_valid_q;
    logic [WIDTH-1:0]     s1_a_q;
    logic [WIDTH-1:0]     s1_b_q;
    logic [LOGIC_OPW-1:0] s1_op_q;
    logic                 s1_acc_q;

    // Stage 2
    logic                 s2_valid_q;
    logic [WIDTH-1:0]     s2_data_q;
    logic                 s2_zero_q;
    logic                 s2_ones_q;
    logic                 s2_parity_q;

    logic [WIDTH-1:0]     acc_q;

    logic                 s1_adv;
    logic                 in_fire;
    logic [WIDTH-1:0]     eff_a;
    logic [WIDTH-1:0]     res_d;
    logic                 zero_d;
    logic                 ones_d;
    logic                 parity_d;

    assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;

    // The accumulator is only written here, at the single compute point, so a
    // back-to-back acc beat always sees the result of the beat just ahead.
    assign eff_a = s1_acc_q ? acc_q : s1_a_q;

    logic_op_comb #(
        .WIDTH (WIDTH)
    ) u_logic_op (
        .a_i      (eff_a),
        .b_i      (s1_b_q),
        .op_i     (s1_op_q),
        .result_o (res_d),
        .zero_o   (zero_d),
        .ones_o   (ones_d),
        .parity_o (parity_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_acc_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_zero_q   <= 1'b1;
            s2_ones_q   <= 1'b0;
            s2_parity_q <= 1'b0;
            acc_q       <= ACC_RESET;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= in_a;
                s1_b_q     <= in_b;
                s1_op_q    <= in_op;
                s1_acc_q   <= in_acc;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid_q  <= 1'b1;
                s2_data_q   <= res_d;
                s2_zero_q   <= zero_d;
                s2_ones_q   <= ones_d;
                s2_parity_q <= parity_d;
                acc_q       <= res_d;
            end else if (out_ready) begin
                // Data and flags keep their last values once drained.
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_zero   = s2_zero_q;
    assign out_ones   = s2_ones_q;
    assign out_parity = s2_parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    // 32-bit instance
    logic        in_valid, in_ready, in_acc, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_data;
    logic [2:0]  in_op;
    logic        out_zero, out_ones, out_parity;
    // 8-bit instance
    logic        v8_in_valid, v8_in_ready, v8_in_acc, v8_out_valid, v8_out_ready;
    logic [7:0]  v8_in_a, v8_in_b, v8_out_data;
    logic [2:0]  v8_in_op;
    logic        v8_out_zero, v8_out_ones, v8_out_parity;

    logic_unit_pipe #(.WIDTH(32), .ACC_RESET(32'h0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .out_ones(out_ones),
        .out_parity(out_parity)
    );

    logic_unit_pipe #(.WIDTH(8), .ACC_RESET(8'h0)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(v8_in_valid), .in_ready(v8_in_ready),
        .in_a(v8_in_a), .in_b(v8_in_b), .in_op(v8_in_op), .in_acc(v8_in_acc),
        .out_valid(v8_out_valid), .out_ready(v8_out_ready),
        .out_data(v8_out_data), .out_zero(v8_out_zero), .out_ones(v8_out_ones),
        .out_parity(v8_out_parity)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] sb8[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         seen_in_ready_low = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 32-bit monitor: compares head of scoreboard whenever a result is presented;
    // pops only on an actual transfer, so stalled outputs are checked for stability.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out", out_data, 32'hxxxx_xxxx);
            end else begin
                check("data", out_data, sb[0].data);
                check("zero", 32'(out_zero), 32'(sb[0].data == 32'h0));
                check("ones", 32'(out_ones), 32'(sb[0].data == 32'hFFFF_FFFF));
                check("parity", 32'(out_parity), 32'(^sb[0].data));
                if (out_ready) begin
                    // Presented two cycles after the accepting cycle.
                    if (sb[0].lat) check("latency", 32'(cyc - sb[0].cyc), 32'd2);
                    void'(sb.pop_front());
                end
            end
        end
        if (!reset && in_valid && !in_ready) seen_in_ready_low = 1'b1;
    end

    always @(negedge clk) begin
        if (!reset && v8_out_valid) begin
            if (sb8.size() == 0) begin
                check("w8_unexpected_out", 32'(v8_out_data), 32'hxxxx_xxxx);
            end else begin
                check("w8_data", 32'(v8_out_data), 32'(sb8[0]));
                check("w8_zero", 32'(v8_out_zero), 32'(sb8[0] == 8'h0));
                check("w8_ones", 32'(v8_out_ones), 32'(sb8[0] == 8'hFF));
                check("w8_parity", 32'(v8_out_parity), 32'(^sb8[0]));
                if (v8_out_ready) void'(sb8.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic acc, input logic [31:0] exp, input bit lat);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_acc   = acc;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        e.data = exp;
        e.cyc  = cyc;
        e.lat  = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'hDEAD_BEEF;
        in_op    = 3'd7;
        in_acc   = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [7:0] exp);
        int n = 0;
        v8_in_valid = 1'b1;
        v8_in_a     = a;
        v8_in_b     = b;
        v8_in_op    = op;
        v8_in_acc   = 1'b0;
        @(negedge clk);
        while (!v8_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!v8_in_ready) check("w8_accept_timeout", 32'(v8_in_ready), 32'd1);
        sb8.push_back(exp);
        @(posedge clk);
        #1;
        v8_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || sb8.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(sb.size() + sb8.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] op_exp [8] = '{32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34, 32'hFF0F_EDFF,
                                32'h000F_00CB, 32'h00FF_12CB, 32'hF000_0034, 32'hF0F0_1234};

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_acc = 1'b0; out_ready = 1'b1;
        v8_in_valid = 1'b0; v8_in_a = '0; v8_in_b = '0; v8_in_op = '0; v8_in_acc = 1'b0;
        v8_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd1);
        check("rst_out_ones", 32'(out_ones), 32'd0);
        check("rst_out_parity", 32'(out_parity), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_w8_out_valid", 32'(v8_out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Every op, back-to-back.
        for (int i = 0; i < 8; i++)
            send(32'hF0F0_1234, 32'h0FF0_FF00, 3'(i), 1'b0, op_exp[i], 1'b1);

        // Flag corners.
        send(32'hAAAA_AAAA, 32'h5555_5555, OP_AND, 1'b0, 32'h0000_0000, 1'b1);
        send(32'h0000_0000, 32'h0000_0000, OP_NOR, 1'b0, 32'hFFFF_FFFF, 1'b1);
        send(32'h0000_0001, 32'h1234_5678, OP_PASS, 1'b0, 32'h0000_0001, 1'b1);

        // Accumulate chain; in_a is zero on acc beats so using it would be visible.
        send(32'hFFFF_FFFF, 32'h0000_0000, OP_PASS, 1'b0, 32'hFFFF_FFFF, 1'b1);
        send(32'h0000_0000, 32'h0000_FFFF, OP_AND, 1'b1, 32'h0000_FFFF, 1'b1);
        send(32'h0000_0000, 32'h0000_00FF, OP_XOR, 1'b1, 32'h0000_FF00, 1'b1);
        drain();

        // Backpressure: 3 stalled cycles right after the first result.
        seen_in_ready_low = 1'b0;
        fork
            begin
                send(32'h1111_1111, 32'h0, OP_PASS, 1'b0, 32'h1111_1111, 1'b0);
                send(32'hFFFF_0000, 32'h00FF_00FF, OP_XOR, 1'b0, 32'hFF00_00FF, 1'b0);
                send(32'h0000_F000, 32'h0000_000F, OP_OR, 1'b0, 32'h0000_F00F, 1'b0);
                send(32'hFFFF_FFFF, 32'h0F0F_0F0F, OP_ANDN, 1'b0, 32'hF0F0_F0F0, 1'b0);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_in_ready_dropped", 32'(seen_in_ready_low), 32'd1);

        // Reset with both stages full.
        out_ready = 1'b0;
        send(32'h1234_5678, 32'h0, OP_PASS, 1'b0, 32'h1234_5678, 1'b0);
        send(32'h8765_4321, 32'h0, OP_PASS, 1'b0, 32'h8765_4321, 1'b0);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_zero", 32'(out_zero), 32'd1);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_AND, 1'b1, 32'h0000_0000, 1'b1);
        drain();

        // Narrow instance.
        send8(8'h3C, 8'h0F, OP_XNOR, 8'hCC);
        send8(8'hF0, 8'h0F, OP_AND, 8'h00);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
